// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 binary32 converter with valid/ready flow control.
// Stages: absolute value, leading-one normalise, round-and-pack.
module itof_pipe #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic         in_signed,
    input  logic         in_rtz,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_y,
    output logic         out_inexact
);
    localparam int unsigned PW = $clog2(W);
    localparam int unsigned EW = W + 24;

    logic advance;
    logic v1_q, v2_q, v3_q;

    logic [W-1:0]  mag1_d, mag1_q;
    logic          sign1_d, sign1_q, rtz1_q, zero1_q;

    logic [PW-1:0] p2_d, p2_q;
    logic [22:0]   m2_d, m2_q;
    logic          g2_d, g2_q, s2_d, s2_q, sign2_q, rtz2_q, zero2_q;
    logic [W-2:0]  norm;
    logic [EW-1:0] ext;

    logic          up;
    logic [23:0]   msum;
    logic [7:0]    exp3;
    logic [31:0]   y_d;
    logic          inexact_d;

    // The whole pipe moves as one; it only stalls while the output is held.
    assign advance   = ~v3_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = v3_q;

    always_comb begin
        sign1_d = in_signed & in_x[W-1];
        mag1_d  = sign1_d ? -in_x : in_x;
    end

    always_comb begin
        p2_d = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (mag1_q[i]) p2_d = i[PW-1:0];
        end
        // Leading one is dropped; padding below it supplies zero mantissa/guard bits for small W.
        norm = (W-1)'(mag1_q << (PW'(W - 1) - p2_d));
        ext  = {norm, 25'd0};
        m2_d = ext[EW-1 -: 23];
        g2_d = ext[W];
        s2_d = |ext[W-1:0];
    end

    always_comb begin
        up   = ~rtz2_q & g2_q & (s2_q | m2_q[0]);
        msum = {1'b0, m2_q} + {23'd0, up};
        exp3 = 8'd127 + 8'(p2_q) + {7'd0, msum[23]};
        if (zero2_q) begin
            y_d       = 32'd0;
            inexact_d = 1'b0;
        end else begin
            y_d       = {sign2_q, exp3, msum[23] ? 23'd0 : msum[22:0]};
            inexact_d = g2_q | s2_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            mag1_q      <= '0;
            sign1_q     <= 1'b0;
            rtz1_q      <= 1'b0;
            zero1_q     <= 1'b0;
            p2_q        <= '0;
            m2_q        <= '0;
            g2_q        <= 1'b0;
            s2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            rtz2_q      <= 1'b0;
            zero2_q     <= 1'b0;
            out_y       <= 32'd0;
            out_inexact <= 1'b0;
        end else if (advance) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            mag1_q      <= mag1_d;
            sign1_q     <= sign1_d;
            rtz1_q      <= in_rtz;
            zero1_q     <= (mag1_d == '0);
            p2_q        <= p2_d;
            m2_q        <= m2_d;
            g2_q        <= g2_d;
            s2_q        <= s2_d;
            sign2_q     <= sign1_q;
            rtz2_q      <= rtz1_q;
            zero2_q     <= zero1_q;
            out_y       <= y_d;
            out_inexact <= inexact_d;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Bench for itof_pipe: directed conversions, flow control, reset and a width sweep,
// checked against an arithmetic quotient/remainder rounding model.
module tb_itof_pipe;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic        in_valid = 1'b0, in_signed = 1'b0, in_rtz = 1'b0, out_ready = 1'b1;
    logic [31:0] in_x = 32'd0;
    logic        in_ready, out_valid, out_inexact;
    logic [31:0] out_y;

    logic        sw_valid = 1'b0, sw_signed = 1'b0, sw_rtz = 1'b0;
    logic [7:0]  x8 = 8'd0;
    logic [23:0] x24 = 24'd0;
    logic [63:0] x64 = 64'd0;
    logic        r8, r24, r64, v8, v24, v64, i8, i24, i64;
    logic [31:0] y8, y24, y64;

    itof_pipe #(.W(32)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_signed(in_signed), .in_rtz(in_rtz), .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_inexact(out_inexact)
    );
    itof_pipe #(.W(8)) dut8 (
        .clk(clk), .rstn(rstn), .in_valid(sw_valid), .in_ready(r8), .in_x(x8),
        .in_signed(sw_signed), .in_rtz(sw_rtz), .out_valid(v8), .out_ready(1'b1),
        .out_y(y8), .out_inexact(i8)
    );
    itof_pipe #(.W(24)) dut24 (
        .clk(clk), .rstn(rstn), .in_valid(sw_valid), .in_ready(r24), .in_x(x24),
        .in_signed(sw_signed), .in_rtz(sw_rtz), .out_valid(v24), .out_ready(1'b1),
        .out_y(y24), .out_inexact(i24)
    );
    itof_pipe #(.W(64)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(sw_valid), .in_ready(r64), .in_x(x64),
        .in_signed(sw_signed), .in_rtz(sw_rtz), .out_valid(v64), .out_ready(1'b1),
        .out_y(y64), .out_inexact(i64)
    );

    // Returns {inexact, y}. Rounds by integer quotient and remainder against a power of two.
    function automatic logic [32:0] ref_conv(input logic [63:0] x, input int w,
                                             input logic sgn, input logic rtz);
        logic [63:0] mask, mag, q, rem, half;
        logic neg, inex;
        int e, sh;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        neg  = sgn && x[w-1];
        mag  = neg ? ((~x + 64'd1) & mask) : (x & mask);
        if (mag == 64'd0) return 33'd0;
        e = 63;
        while (mag[e] == 1'b0) e--;
        inex = 1'b0;
        if (e <= 23) begin
            q = mag << (23 - e);
        end else begin
            sh   = e - 23;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            inex = (rem != 64'd0);
            if (!rtz && (rem > half || (rem == half && q[0]))) q = q + 64'd1;
            if (q == (64'd1 << 24)) begin
                q = 64'd1 << 23;
                e++;
            end
        end
        return {inex, neg, 8'(127 + e), q[22:0]};
    endfunction

    logic [31:0] rx [10] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0100_0001,
                             32'h0100_0003, 32'h0100_0003, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                             32'hFEFF_FFFD, 32'h00FF_FFFF};
    logic        rs [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        rr [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] ry [10] = '{32'h4F00_0000, 32'h4F80_0000, 32'h4F7F_FFFF, 32'h4B80_0000,
                             32'h4B80_0002, 32'h4B80_0001, 32'h4F00_0000, 32'h4EFF_FFFF,
                             32'hCB80_0002, 32'h4B7F_FFFF};
    logic        ri [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_y !== 32'd0) begin n_fail++; $display("FAIL reset_y: got %h want 0", out_y); end
        n_checks++;
        if (out_inexact !== 1'b0) begin n_fail++; $display("FAIL reset_inexact: got %b want 0", out_inexact); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        n_checks++;
        if ({v8, v24, v64} !== 3'b000) begin n_fail++; $display("FAIL reset_sweep_valid: got %b want 000", {v8, v24, v64}); end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs [4] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        logic [31:0] ys [4] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hCF00_0000};
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c < 4);
            in_x = (c < 4) ? xs[c] : 32'd0;
            in_signed = 1'b1;
            in_rtz = 1'b0;
            @(posedge clk);
            #1;
            if (c >= 2 && c <= 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_y !== ys[c-2] || out_inexact !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: got v=%b y=%h ix=%b want v=1 y=%h ix=0",
                             c - 2, out_valid, out_y, out_inexact, ys[c-2]);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d: got v=%b want 0", c, out_valid); end
            end
        end
    endtask

    task automatic test_rounding();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10);
            in_x = (c < 10) ? rx[c] : 32'd0;
            in_signed = (c < 10) ? rs[c] : 1'b0;
            in_rtz = (c < 10) ? rr[c] : 1'b0;
            @(posedge clk);
            #1;
            if (c >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_y !== ry[c-2] || out_inexact !== ri[c-2]) begin
                    n_fail++;
                    $display("FAIL round_%0d: got v=%b y=%h ix=%b want v=1 y=%h ix=%b",
                             c - 2, out_valid, out_y, out_inexact, ry[c-2], ri[c-2]);
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [32:0] q[$];
        logic [32:0] e;
        logic [31:0] held_y = 32'd0;
        logic        held_i = 1'b0;
        int sent = 0, got = 0, stall = 0;
        bit seen = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            in_valid = (sent < 8);
            in_x = $urandom;
            in_signed = 1'($urandom_range(0, 1));
            in_rtz = 1'($urandom_range(0, 1));
            if (out_valid && !seen) begin
                seen = 1'b1;
                stall = 5;
                held_y = out_y;
                held_i = out_inexact;
            end
            out_ready = (stall == 0);
            #1;
            if (!out_ready) begin
                n_checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_y !== held_y || out_inexact !== held_i) begin
                    n_fail++;
                    $display("FAIL bp_stall: got v=%b rdy=%b y=%h ix=%b want v=1 rdy=0 y=%h ix=%b",
                             out_valid, in_ready, out_y, out_inexact, held_y, held_i);
                end
                stall--;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_conv({32'd0, in_x}, 32, in_signed, in_rtz));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_extra: got y=%h want no output", out_y);
                end else begin
                    e = q.pop_front();
                    if ({out_inexact, out_y} !== e) begin
                        n_fail++;
                        $display("FAIL bp_data_%0d: got y=%h ix=%b want y=%h ix=%b",
                                 got, out_y, out_inexact, e[31:0], e[32]);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b pending=%0d want v=0 pending=0", out_valid, q.size());
        end
    endtask

    task automatic test_random_flow();
        logic [32:0] q[$];
        logic [32:0] e;
        logic [31:0] prev_y = 32'd0;
        logic        prev_i = 1'b0;
        bit prev_hold = 1'b0;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 600 && got < 60; cyc++) begin
            in_valid = (sent < 60) && ($urandom_range(0, 9) < 7);
            in_x = $urandom;
            in_signed = 1'($urandom_range(0, 1));
            in_rtz = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            if (prev_hold) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_y !== prev_y || out_inexact !== prev_i) begin
                    n_fail++;
                    $display("FAIL flow_hold: got v=%b y=%h ix=%b want v=1 y=%h ix=%b",
                             out_valid, out_y, out_inexact, prev_y, prev_i);
                end
            end
            n_checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++;
                $display("FAIL flow_ready: got %b want %b", in_ready, !out_valid || out_ready);
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_conv({32'd0, in_x}, 32, in_signed, in_rtz));
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL flow_extra: got y=%h want no output", out_y);
                end else begin
                    e = q.pop_front();
                    if ({out_inexact, out_y} !== e) begin
                        n_fail++;
                        $display("FAIL flow_data_%0d: got y=%h ix=%b want y=%h ix=%b",
                                 got, out_y, out_inexact, e[31:0], e[32]);
                    end
                end
                got++;
            end
            prev_hold = out_valid && !out_ready;
            prev_y = out_y;
            prev_i = out_inexact;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (got != 60) begin n_fail++; $display("FAIL flow_count: got %0d want 60", got); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_x = $urandom_range(1, 1000);
            in_signed = 1'b0;
            in_rtz = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b want 1", out_valid); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_y !== 32'd0 || out_inexact !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b y=%h ix=%b rdy=%b want v=0 y=0 ix=0 rdy=1",
                     out_valid, out_y, out_inexact, in_ready);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_x = 32'd5;
        in_signed = 1'b1;
        in_rtz = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (k == 3) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_y !== 32'h40A0_0000 || out_inexact !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rst_new_op: got v=%b y=%h ix=%b want v=1 y=40a00000 ix=0",
                             out_valid, out_y, out_inexact);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_idle_%0d: got v=%b want 0", k, out_valid); end
            end
        end
    endtask

    task automatic test_sweep();
        logic [32:0] q8[$], q24[$], q64[$];
        logic [32:0] e;
        for (int c = 0; c < 45; c++) begin
            if (c < 40) begin
                sw_valid = 1'b1;
                if (c == 0) begin
                    sw_signed = 1'b1;
                    sw_rtz = 1'b0;
                    x8 = 8'h80;
                    x64 = 64'h8000_0000_0000_0000;
                end else begin
                    sw_signed = 1'($urandom_range(0, 1));
                    sw_rtz = 1'($urandom_range(0, 1));
                    x8 = 8'($urandom);
                    x64 = {$urandom, $urandom};
                end
                x24 = 24'($urandom);
                if (r8) q8.push_back(ref_conv({56'd0, x8}, 8, sw_signed, sw_rtz));
                if (r24) q24.push_back(ref_conv({40'd0, x24}, 24, sw_signed, sw_rtz));
                if (r64) q64.push_back(ref_conv(x64, 64, sw_signed, sw_rtz));
            end else begin
                sw_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c == 2) begin
                n_checks++;
                if (v8 !== 1'b1 || y8 !== 32'hC300_0000) begin
                    n_fail++;
                    $display("FAIL w8_min: got v=%b y=%h want v=1 y=c3000000", v8, y8);
                end
                n_checks++;
                if (v64 !== 1'b1 || y64 !== 32'hDF00_0000) begin
                    n_fail++;
                    $display("FAIL w64_min: got v=%b y=%h want v=1 y=df000000", v64, y64);
                end
            end
            if (v8) begin
                n_checks++;
                e = (q8.size() != 0) ? q8.pop_front() : 33'h1_FFFF_FFFF;
                if ({i8, y8} !== e) begin
                    n_fail++;
                    $display("FAIL w8_data: got y=%h ix=%b want y=%h ix=%b", y8, i8, e[31:0], e[32]);
                end
            end
            if (v24) begin
                n_checks++;
                e = (q24.size() != 0) ? q24.pop_front() : 33'h1_FFFF_FFFF;
                if ({i24, y24} !== e || i24 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL w24_data: got y=%h ix=%b want y=%h ix=0", y24, i24, e[31:0]);
                end
            end
            if (v64) begin
                n_checks++;
                e = (q64.size() != 0) ? q64.pop_front() : 33'h1_FFFF_FFFF;
                if ({i64, y64} !== e) begin
                    n_fail++;
                    $display("FAIL w64_data: got y=%h ix=%b want y=%h ix=%b", y64, i64, e[31:0], e[32]);
                end
            end
        end
        n_checks++;
        if (q8.size() != 0 || q24.size() != 0 || q64.size() != 0) begin
            n_fail++;
            $display("FAIL sweep_pending: got %0d/%0d/%0d want 0/0/0", q8.size(), q24.size(), q64.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rounding();
        test_backpressure();
        test_random_flow();
        test_reset_midstream();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
